// File: rtl/team_05_pkg.sv
// Shared constants for the team_05 GPIO Wishbone slave: pin count, register
// word offsets and the all-inputs reset value of the output-enable register.
package team_05_pkg;

    localparam int GPIO_W = 34;

    // Word offsets, i.e. wbs_adr_i[4:2]
    localparam logic [2:0] OFF_OUT_LO  = 3'd0;
    localparam logic [2:0] OFF_OUT_HI  = 3'd1;
    localparam logic [2:0] OFF_OEB_LO  = 3'd2;
    localparam logic [2:0] OFF_OEB_HI  = 3'd3;
    localparam logic [2:0] OFF_IN_LO   = 3'd4;
    localparam logic [2:0] OFF_IN_HI   = 3'd5;
    localparam logic [2:0] OFF_EDGE_LO = 3'd6;
    localparam logic [2:0] OFF_EDGE_HI = 3'd7;

    localparam logic [GPIO_W-1:0] OEB_RST = {GPIO_W{1'b1}};

    function automatic logic [31:0] byteMask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/team_05_sync2.sv
// Two-flop synchronizer bringing asynchronous pad inputs into the clk domain.
module team_05_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/team_05_gpio_wb_slave.sv
// Wishbone classic slave exposing GPIO output/enable registers, synchronized
// inputs and sticky rising-edge flags with a registered interrupt.
module team_05_gpio_wb_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          GPIO_W    = team_05_pkg::GPIO_W
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oeb,
    output logic              irq_o
);

    import team_05_pkg::*;

    localparam int HW = GPIO_W - 32;

    logic [GPIO_W-1:0] out_q, out_d;
    logic [GPIO_W-1:0] oeb_q, oeb_d;
    logic [GPIO_W-1:0] edgeFlags_q, edgeFlags_d;
    logic [GPIO_W-1:0] prevIn_q;
    logic [GPIO_W-1:0] syncIn;
    logic [GPIO_W-1:0] rise;
    logic [GPIO_W-1:0] clrMask;
    logic              ack_q;
    logic              irq_q, irq_d;
    logic [31:0]       dat_q, dat_d;
    logic              hit;
    logic [2:0]        wordSel;
    logic [31:0]       wMask;
    logic              unusedAdr;

    team_05_sync2 #(.W(GPIO_W)) uSync (
        .clk  (clk),
        .nrst (nrst),
        .d_i  (gpio_in),
        .q_o  (syncIn)
    );

    // The !ack term forces a one-cycle gap, so a held strobe re-hits every other cycle
    assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]) & ~ack_q;
    assign wordSel   = wbs_adr_i[4:2];
    assign wMask     = byteMask(wbs_sel_i);
    assign rise      = syncIn & ~prevIn_q;
    assign unusedAdr = ^wbs_adr_i[1:0];

    always_comb begin
        out_d   = out_q;
        oeb_d   = oeb_q;
        clrMask = '0;
        dat_d   = '0;
        if (hit && wbs_we_i) begin
            case (wordSel)
                OFF_OUT_LO:  out_d[31:0]        = (out_q[31:0] & ~wMask) | (wbs_dat_i & wMask);
                OFF_OUT_HI:  out_d[GPIO_W-1:32] = (out_q[GPIO_W-1:32] & ~wMask[HW-1:0])
                                                | (wbs_dat_i[HW-1:0] & wMask[HW-1:0]);
                OFF_OEB_LO:  oeb_d[31:0]        = (oeb_q[31:0] & ~wMask) | (wbs_dat_i & wMask);
                OFF_OEB_HI:  oeb_d[GPIO_W-1:32] = (oeb_q[GPIO_W-1:32] & ~wMask[HW-1:0])
                                                | (wbs_dat_i[HW-1:0] & wMask[HW-1:0]);
                OFF_EDGE_LO: clrMask[31:0]        = wbs_dat_i & wMask;
                OFF_EDGE_HI: clrMask[GPIO_W-1:32] = wbs_dat_i[HW-1:0] & wMask[HW-1:0];
                default: ;
            endcase
        end
        if (hit && !wbs_we_i) begin
            case (wordSel)
                OFF_OUT_LO:  dat_d = out_q[31:0];
                OFF_OUT_HI:  dat_d = 32'(out_q[GPIO_W-1:32]);
                OFF_OEB_LO:  dat_d = oeb_q[31:0];
                OFF_OEB_HI:  dat_d = 32'(oeb_q[GPIO_W-1:32]);
                OFF_IN_LO:   dat_d = syncIn[31:0];
                OFF_IN_HI:   dat_d = 32'(syncIn[GPIO_W-1:32]);
                OFF_EDGE_LO: dat_d = edgeFlags_q[31:0];
                OFF_EDGE_HI: dat_d = 32'(edgeFlags_q[GPIO_W-1:32]);
                default: ;
            endcase
        end
        // A new rising edge beats a simultaneous W1C on the same bit
        edgeFlags_d = (edgeFlags_q & ~clrMask) | rise;
        irq_d       = |edgeFlags_d;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_q       <= '0;
            oeb_q       <= OEB_RST;
            edgeFlags_q <= '0;
            prevIn_q    <= '0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            irq_q       <= 1'b0;
        end else begin
            out_q       <= out_d;
            oeb_q       <= oeb_d;
            edgeFlags_q <= edgeFlags_d;
            prevIn_q    <= syncIn;
            ack_q       <= hit;
            dat_q       <= dat_d;
            irq_q       <= irq_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;
    assign gpio_out  = en ? out_q : '0;
    assign gpio_oeb  = en ? oeb_q : '1;

endmodule

// File: tb/tb_team_05_gpio_wb_slave.sv
// Randomized bench for team_05_gpio_wb_slave against a register-array model
// built from the bus, input-history and edge-flag rules of the GPIO slave.
module tb_team_05_gpio_wb_slave;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk;
    logic        nrst;
    logic        en;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [33:0] gpio_in, gpio_out, gpio_oeb;
    logic        irq_o;

    int checks = 0;
    int errors = 0;
    bit checkOn = 0;

    team_05_gpio_wb_slave #(.BASE_ADDR(BASE), .GPIO_W(34)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .en        (en),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oeb  (gpio_oeb),
        .irq_o     (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: register words 0..3 stored as plain words, inputs kept
    // as a history of values seen at each clock edge since reset.
    logic [31:0] mReg [4];
    logic [33:0] mEdge;
    logic        mAck, mIrq, mRead;
    logic [31:0] mDat;
    logic [33:0] hist [$];

    function automatic logic [33:0] histAt(input int i);
        if (i < 0 || i >= hist.size()) return '0;
        return hist[i];
    endfunction

    function automatic logic [31:0] implMask(input int idx);
        return (idx == 1 || idx == 3) ? 32'h3 : 32'hFFFF_FFFF;
    endfunction

    always @(posedge clk or negedge nrst) begin : model
        int          k, idx;
        logic [33:0] rise, clr, inNow;
        logic [31:0] m, rd;
        bit          hit;
        if (!nrst) begin
            mReg[0] = '0; mReg[1] = '0; mReg[2] = 32'hFFFF_FFFF; mReg[3] = 32'h3;
            mEdge = '0; mAck = 0; mIrq = 0; mRead = 0; mDat = '0;
            hist.delete();
        end else begin
            hist.push_back(gpio_in);
            k     = hist.size() - 1;
            inNow = histAt(k - 2);
            rise  = histAt(k - 2) & ~histAt(k - 3);
            hit   = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:5] == BASE[31:5]) && !mAck;
            m = '0;
            for (int b = 0; b < 4; b++) if (wbs_sel_i[b]) m[8*b +: 8] = 8'hFF;
            idx = int'(wbs_adr_i[4:2]);
            clr = '0;
            rd  = '0;
            if (hit && wbs_we_i) begin
                if (idx < 4) mReg[idx] = ((mReg[idx] & ~m) | (wbs_dat_i & m)) & implMask(idx);
                else if (idx == 6) clr[31:0] = wbs_dat_i & m;
                else if (idx == 7) clr[33:32] = wbs_dat_i[1:0] & m[1:0];
            end else if (hit) begin
                case (idx)
                    0, 1, 2, 3: rd = mReg[idx];
                    4:          rd = inNow[31:0];
                    5:          rd = {30'b0, inNow[33:32]};
                    6:          rd = mEdge[31:0];
                    default:    rd = {30'b0, mEdge[33:32]};
                endcase
            end
            mEdge = (mEdge & ~clr) | rise;
            mIrq  = |mEdge;
            mAck  = hit;
            mRead = hit && !wbs_we_i;
            mDat  = rd;
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (checkOn && nrst) begin
            checkOutput("ack", wbs_ack_o, mAck);
            checkOutput("irq", irq_o, mIrq);
            checkOutput("gpio_out", gpio_out, en ? {mReg[1][1:0], mReg[0]} : 34'h0);
            checkOutput("gpio_oeb", gpio_oeb, en ? {mReg[3][1:0], mReg[2]} : {34{1'b1}});
            if (wbs_ack_o && mRead) checkOutput("rdata", wbs_dat_o, mDat);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus transfer; lat counts clock edges from strobe to visible ack
    task automatic applyStimulus(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                                 input logic [31:0] dat, output logic [31:0] rdata,
                                 output int lat, output bit gotAck);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_sel_i = sel; wbs_dat_i = dat;
        lat = 0; gotAck = 0; rdata = '0;
        for (int i = 0; i < 6 && !gotAck; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (wbs_ack_o) begin
                gotAck = 1;
                rdata  = wbs_dat_o;
            end
        end
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        tick(1);
    endtask

    task automatic wbWrite(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        logic [31:0] rd;
        int          lat;
        bit          got;
        applyStimulus(1, adr, sel, dat, rd, lat, got);
        checkOutput("writeAck", got, 1);
    endtask

    task automatic wbRead(input logic [31:0] adr, output logic [31:0] rd);
        int lat;
        bit got;
        applyStimulus(0, adr, 4'hF, 32'h0, rd, lat, got);
        checkOutput("readAck", got, 1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd, adr;
        int          lat;
        bit          got;
        int          r;

        nrst = 0; en = 1; gpio_in = '0;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
        tick(3);
        checkOutput("rstOeb", gpio_oeb, 34'h3_FFFF_FFFF);
        checkOutput("rstAck", wbs_ack_o, 0);
        nrst = 1;
        checkOn = 1;
        tick(2);
        checkOutput("idleOeb", gpio_oeb, 34'h3_FFFF_FFFF);
        checkOutput("idleOut", gpio_out, 34'h0);
        checkOutput("idleAck", wbs_ack_o, 0);
        checkOutput("idleIrq", irq_o, 0);

        $display("[TB] byte-enable write and read-back");
        wbWrite(BASE + 32'h00, 4'b0101, 32'hDEAD_BEEF);
        checkOutput("outPins", gpio_out, 34'h0_00AD_00EF);
        applyStimulus(0, BASE + 32'h00, 4'hF, 32'h0, rd, lat, got);
        checkOutput("readOutAck", got, 1);
        checkOutput("readOutLo", rd, 32'h00AD_00EF);
        checkOutput("ackLatency", lat, 1);

        $display("[TB] output enable and chip enable override");
        wbWrite(BASE + 32'h0C, 4'hF, 32'h3);
        wbWrite(BASE + 32'h08, 4'hF, 32'h0);
        checkOutput("oebEn", gpio_oeb, 34'h3_0000_0000);
        en = 0;
        #1;
        checkOutput("oebDis", gpio_oeb, 34'h3_FFFF_FFFF);
        checkOutput("outDis", gpio_out, 34'h0);
        wbRead(BASE + 32'h08, rd);
        checkOutput("oebLoKept", rd, 32'h0);
        wbRead(BASE + 32'h0C, rd);
        checkOutput("oebHiKept", rd, 32'h3);
        en = 1;
        tick(1);

        $display("[TB] input sync and edge flag on pin 33");
        gpio_in[33] = 1'b1;
        tick(2);
        checkOutput("irqEdge2", irq_o, 0);
        tick(1);
        checkOutput("irqEdge3", irq_o, 1);
        wbRead(BASE + 32'h14, rd);
        checkOutput("inHi", rd, 32'h2);
        wbRead(BASE + 32'h1C, rd);
        checkOutput("edgeHi", rd, 32'h2);
        wbWrite(BASE + 32'h1C, 4'hF, 32'h2);
        checkOutput("irqCleared", irq_o, 0);
        wbRead(BASE + 32'h1C, rd);
        checkOutput("edgeHiClr", rd, 32'h0);

        $display("[TB] set beats clear on the same edge");
        gpio_in[0] = 1'b1;
        tick(4);
        gpio_in[0] = 1'b0;
        tick(4);
        gpio_in[0] = 1'b1;
        tick(2);
        wbWrite(BASE + 32'h18, 4'hF, 32'h1);
        wbRead(BASE + 32'h18, rd);
        checkOutput("setWins", rd[0], 1);
        wbWrite(BASE + 32'h18, 4'hF, 32'h1);
        wbRead(BASE + 32'h18, rd);
        checkOutput("edgeLoClr", rd, 32'h0);
        gpio_in[15:8] = 8'hFF;
        tick(4);
        wbWrite(BASE + 32'h18, 4'b0001, 32'hFFFF_FFFF);
        wbRead(BASE + 32'h18, rd);
        checkOutput("w1cSel", rd, 32'h0000_FF00);

        $display("[TB] out-of-window access");
        applyStimulus(0, BASE + 32'h40, 4'hF, 32'h0, rd, lat, got);
        checkOutput("missRead", got, 0);
        applyStimulus(1, BASE + 32'h40, 4'hF, 32'hFFFF_FFFF, rd, lat, got);
        checkOutput("missWrite", got, 0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 1) begin
                gpio_in = {2'($urandom_range(0, 3)), 32'($urandom)};
                tick(1);
            end else if (r == 2) begin
                en = ($urandom_range(0, 4) != 0);
                tick(1);
            end else if (r <= 5) begin
                wbWrite(BASE + {27'h0, 3'($urandom_range(0, 7)), 2'b00}, 4'($urandom), 32'($urandom));
            end else if (r <= 8) begin
                wbRead(BASE + {27'h0, 3'($urandom_range(0, 7)), 2'b00}, rd);
            end else begin
                adr = 32'($urandom);
                if (adr[31:5] == BASE[31:5]) adr = adr ^ 32'h8000_0000;
                applyStimulus(r[0], adr, 4'hF, 32'($urandom), rd, lat, got);
                checkOutput("missRand", got, 0);
            end
        end
        en = 1;
        tick(1);

        $display("[TB] held strobe and reset mid-transaction");
        wbWrite(BASE + 32'h00, 4'hF, 32'h1234_5678);
        wbWrite(BASE + 32'h04, 4'hF, 32'h3);
        checkOutput("outBeforeRst", gpio_out, 34'h3_1234_5678);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0;
        wbs_adr_i = BASE + 32'h10; wbs_sel_i = 4'hF;
        got = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            got = wbs_ack_o;
        end
        checkOutput("heldAck", got, 1);
        @(negedge clk);
        checkOutput("ackDrop", wbs_ack_o, 0);
        @(negedge clk);
        checkOutput("heldRetry", wbs_ack_o, 1);
        #2;
        nrst = 0;
        #1;
        checkOutput("rstAckAsync", wbs_ack_o, 0);
        checkOutput("rstOutAsync", gpio_out, 34'h0);
        checkOutput("rstOebAsync", gpio_oeb, 34'h3_FFFF_FFFF);
        checkOutput("rstIrqAsync", irq_o, 0);
        wbs_cyc_i = 0; wbs_stb_i = 0;
        tick(2);
        nrst = 1;
        tick(2);
        checkOutput("postRstOut", gpio_out, 34'h0);
        wbRead(BASE + 32'h00, rd);
        checkOutput("postRstOutReg", rd, 32'h0);

        checkOn = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
